// File: rtl/demux_pkg.sv
// Shared select encodings and types for the registered 1-to-4 demultiplexer.
package demux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_O0 = 2'b00;
    localparam sel_t SEL_O1 = 2'b01;
    localparam sel_t SEL_O2 = 2'b10;
    localparam sel_t SEL_O3 = 2'b11;

    localparam int NUM_OUTS = 4;

endpackage

// File: rtl/demux_1to4_d_if.sv
// Producer-side word/select and the four steered consumer words.
interface demux_1to4_d_if #(
    parameter int width = 32
);
    import demux_pkg::*;

    logic [width-1:0] i;
    sel_t             sel;
    logic [width-1:0] o0;
    logic [width-1:0] o1;
    logic [width-1:0] o2;
    logic [width-1:0] o3;

    modport master (
        output i,
        output sel,
        input  o0,
        input  o1,
        input  o2,
        input  o3
    );

    modport slave (
        input  i,
        input  sel,
        output o0,
        output o1,
        output o2,
        output o3
    );

endinterface

// File: rtl/demux_out_reg.sv
// One steered output word: loads d when enabled, otherwise clears; sync reset.
module demux_out_reg #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] q_d;
    logic [width-1:0] q_q;

    // Deselected outputs clear rather than hold their last value.
    always_comb begin
        q_d = '0;
        if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/demux_1to4_d.sv
// Registered 1-to-4 demux: i lands on o[sel] one edge later, all other outputs go to zero.
module demux_1to4_d
    import demux_pkg::*;
#(
    parameter int width = 32
) (
    input  logic           clk,
    input  logic           rst,
    demux_1to4_d_if.slave  bus
);

    logic [NUM_OUTS-1:0] en_d;
    logic [width-1:0]    q [NUM_OUTS];

    // Any unresolved select falls through to o3.
    always_comb begin
        en_d = '0;
        case (bus.sel)
            SEL_O0:  en_d = 4'b0001;
            SEL_O1:  en_d = 4'b0010;
            SEL_O2:  en_d = 4'b0100;
            default: en_d = 4'b1000;
        endcase
    end

    for (genvar g = 0; g < NUM_OUTS; g++) begin : g_out
        demux_out_reg #(
            .width(width)
        ) u_reg (
            .clk  (clk),
            .rst  (rst),
            .load (en_d[g]),
            .d    (bus.i),
            .q    (q[g])
        );
    end

    assign bus.o0 = q[0];
    assign bus.o1 = q[1];
    assign bus.o2 = q[2];
    assign bus.o3 = q[3];

endmodule

// File: tb/tb_demux_1to4_d.sv
// Directed + random checks of demux_1to4_d against a per-edge routing model.
module tb_demux_1to4_d;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    demux_1to4_d_if #(.width(32)) bus ();
    demux_1to4_d_if #(.width(8))  bus8 ();

    demux_1to4_d #(.width(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    demux_1to4_d #(.width(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    // Model: after each edge, output k holds i if it was selected and not in reset, else zero.
    logic [31:0] m_o [4];
    bit          m_valid = 0;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            m_o[k] = (!rst && (int'(bus.sel) == k)) ? bus.i : 32'h0;
        end
        m_valid = 1;
    end

    function automatic logic [31:0] dut_out(input int k);
        case (k)
            0:       return bus.o0;
            1:       return bus.o1;
            2:       return bus.o2;
            default: return bus.o3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("model_o%0d", k), dut_out(k), m_o[k]);
            end
        end
    end

    task automatic drive(input logic r, input logic [31:0] iv, input logic [1:0] s);
        @(negedge clk);
        #1;
        rst     = r;
        bus.i   = iv;
        bus.sel = s;
    endtask

    task automatic edge_then_check(input string name, input logic [31:0] e0, input logic [31:0] e1,
                                   input logic [31:0] e2, input logic [31:0] e3);
        @(posedge clk);
        #1;
        chk({name, "_o0"}, bus.o0, e0);
        chk({name, "_o1"}, bus.o1, e1);
        chk({name, "_o2"}, bus.o2, e2);
        chk({name, "_o3"}, bus.o3, e3);
    endtask

    logic [31:0] sweep_i [4] = '{32'hA0000000, 32'hB0000000, 32'hC0000000, 32'hD0000000};

    initial begin
        rst      = 1'b1;
        bus.i    = 32'hFFFFFFFF;
        bus.sel  = 2'b10;
        bus8.i   = 8'hFF;
        bus8.sel = 2'b10;

        edge_then_check("reset1", 32'h0, 32'h0, 32'h0, 32'h0);
        edge_then_check("reset2", 32'h0, 32'h0, 32'h0, 32'h0);
        chk("reset_w8_o2", {24'h0, bus8.o2}, 32'h0);

        for (int k = 0; k < 4; k++) begin
            drive(1'b0, sweep_i[k], 2'(k));
            edge_then_check($sformatf("sweep%0d", k),
                            (k == 0) ? sweep_i[k] : 32'h0,
                            (k == 1) ? sweep_i[k] : 32'h0,
                            (k == 2) ? sweep_i[k] : 32'h0,
                            (k == 3) ? sweep_i[k] : 32'h0);
        end

        drive(1'b0, 32'h12345678, 2'b00);
        edge_then_check("desel_a", 32'h12345678, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 32'h9ABCDEF0, 2'b11);
        edge_then_check("desel_b", 32'h0, 32'h0, 32'h0, 32'h9ABCDEF0);

        drive(1'b1, 32'hDEADBEEF, 2'b01);
        edge_then_check("rstprio", 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 32'hDEADBEEF, 2'b01);
        edge_then_check("rstrel", 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);

        // Mid-cycle input change must not reach the outputs before the next edge.
        drive(1'b0, 32'h55555555, 2'b10);
        bus8.i   = 8'h5A;
        bus8.sel = 2'b10;
        #2;
        chk("latency_hold_o1", bus.o1, 32'hDEADBEEF);
        chk("latency_hold_o2", bus.o2, 32'h0);
        edge_then_check("latency_load", 32'h0, 32'h0, 32'h55555555, 32'h0);
        chk("w8_o0", {24'h0, bus8.o0}, 32'h0);
        chk("w8_o1", {24'h0, bus8.o1}, 32'h0);
        chk("w8_o2", {24'h0, bus8.o2}, 32'h5A);
        chk("w8_o3", {24'h0, bus8.o3}, 32'h0);

        for (int n = 0; n < 1000; n++) begin
            drive(($urandom_range(0, 31) == 0), $urandom, 2'($urandom_range(0, 3)));
        end
        drive(1'b0, 32'h0, 2'b00);
        edge_then_check("zero_in", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
